// File: rtl/x_input_feeder.sv
// x_input_feeder: buffers host bytes in a DEPTH-entry FIFO and streams them to the matrix core as N_ELEM-byte X frames.
// Latency: 3 cycles from a push into an empty FIFO in IDLE to that byte on X_load with valid_input (push, START, pop register).
// Backpressure: host_ready drops while the FIFO holds DEPTH bytes; the core cannot stall a frame, the FIFO simply drains as bytes arrive.
module x_input_feeder #(
   parameter int DEPTH  = 8,
   parameter int N_ELEM = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] host_data,
   input  logic       host_valid,
   output logic       host_ready,
   input  logic       finish,
   output logic       start_in,
   output logic [7:0] X_load,
   output logic       valid_input,
   output logic       busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] START     = 2'd1;
   localparam logic [1:0] STREAM    = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [5:0]    elem_cnt;
   logic          push;
   logic          pop;
   logic          last_elem;

   // Ready comes straight from the registered occupancy, so it never depends on host_valid.
   assign host_ready = (count != CW'(DEPTH));
   assign push       = host_valid & host_ready;
   // Pops look only at the count at the start of the cycle: a byte landing in an empty FIFO waits one cycle.
   assign pop        = (state == STREAM) && (count != '0);
   assign last_elem  = (elem_cnt == 6'(N_ELEM - 1));
   assign busy       = (state != IDLE);

   // Frame sequencing: finish only matters once the whole frame has been handed over.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (count != '0) state_nxt = START;
         START:     state_nxt = STREAM;
         STREAM:    if (pop && last_elem) state_nxt = WAIT_DONE;
         WAIT_DONE: if (finish) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // FSM, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   // Byte storage; contents are don't-care until written, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= host_data;
   end

   // Core-facing registers and per-frame element count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         elem_cnt    <= '0;
         start_in    <= 1'b0;
         valid_input <= 1'b0;
         X_load      <= 8'h00;
      end else begin
         if (state == START)
            elem_cnt <= '0;
         else if (pop)
            elem_cnt <= elem_cnt + 6'd1;
         // High exactly while the FSM sits in START.
         start_in    <= (state_nxt == START);
         valid_input <= pop;
         if (pop) X_load <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_x_input_feeder.sv
// Testbench for x_input_feeder: random host traffic, scoreboard of accepted bytes, frame-level finish handling.
// Latency: checks the 1-cycle push-to-start and 3-cycle push-to-beat figures after reset.
// Backpressure: exercises a full FIFO while the core holds the feeder in its done-wait.
module tb_x_input_feeder;

   localparam int DEPTH  = 8;
   localparam int N_ELEM = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] host_data = 8'h00;
   logic       host_valid = 1'b0;
   logic       host_ready;
   logic       finish = 1'b0;
   logic       start_in;
   logic [7:0] X_load;
   logic       valid_input;
   logic       busy;

   always #5 clk = ~clk;

   x_input_feeder #(.DEPTH(DEPTH), .N_ELEM(N_ELEM)) dut (
      .clk(clk), .rst(rst), .host_data(host_data), .host_valid(host_valid),
      .host_ready(host_ready), .finish(finish), .start_in(start_in),
      .X_load(X_load), .valid_input(valid_input), .busy(busy)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [$];
   int         cyc = 0;
   int         frame_beats = 0;
   int         frames_full = 0;
   int         frames_handled = 0;
   int         starts = 0;
   logic [7:0] last_x = 8'h00;
   bit         track = 0;
   bit         seen_start = 0;
   bit         seen_beat = 0;
   int         start_cyc = 0;
   int         beat_cyc = 0;
   int         push_cyc = 0;
   logic [7:0] beat_val = 8'h00;
   bit         abort = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: accepted bytes are queued, every valid_input beat must be the oldest one.
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         frame_beats = 0;
         last_x = 8'h00;
      end else begin
         if (host_valid && host_ready) exp_q.push_back(host_data);
         if (start_in) begin
            chk("start_excludes_valid", valid_input, 0);
            starts++;
            frame_beats = 0;
            if (track && !seen_start) begin seen_start = 1; start_cyc = cyc; end
         end
         if (valid_input) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_beat: X_load %0h with nothing outstanding (t=%0t)", X_load, $time);
            end else begin
               chk("x_load_order", X_load, exp_q.pop_front());
            end
            frame_beats++;
            if (frame_beats == N_ELEM) frames_full++;
            last_x = X_load;
            if (track && !seen_beat) begin seen_beat = 1; beat_cyc = cyc; beat_val = X_load; end
         end else begin
            chk("x_load_hold", X_load, last_x);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push_one(input logic [7:0] d);
      int n = 0;
      if (abort) return;
      host_valid = 1'b1;
      host_data  = d;
      forever begin
         @(negedge clk);
         if (abort) break;
         if (host_ready) begin
            @(posedge clk); #1;
            push_cyc = cyc;
            break;
         end
         n++;
         if (n > 3000) begin
            checks++; errors++;
            $display("FAIL push_timeout: host_ready stuck at %0b, expected 1", host_ready);
            break;
         end
      end
      host_valid = 1'b0;
   endtask

   task automatic push_seq(input int n, input logic [7:0] base, input bit rnd, input int gmin, input int gmax);
      for (int i = 0; i < n; i++) begin
         if (abort) break;
         push_one(rnd ? 8'($urandom) : 8'(base + i));
         idle($urandom_range(gmax, gmin));
      end
   endtask

   task automatic wait_frame_full(output bit ok);
      int target = frames_handled + 1;
      ok = 0;
      for (int n = 0; n < 3000; n++) begin
         if (frames_full >= target) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      frames_handled++;
      chk("frame_complete", ok, 1);
   endtask

   task automatic finish_frame(input int d);
      bit ok;
      wait_frame_full(ok);
      idle(d - 1);
      finish = 1'b1;
      @(negedge clk); chk("busy_during_finish", busy, 1);
      @(posedge clk); #1; finish = 1'b0;
      @(negedge clk); chk("busy_after_finish", busy, 0);
      @(posedge clk); #1;
   endtask

   task automatic wait_beats(input int lo, output bit ok);
      ok = 0;
      for (int n = 0; n < 3000; n++) begin
         if (frame_beats >= lo && frame_beats < N_ELEM) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk("reach_element", ok, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int  s0, p0, acc;
      bit  ok;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_start_in", start_in, 0);
      chk("rst_valid_input", valid_input, 0);
      chk("rst_x_load", X_load, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_host_ready", host_ready, 1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Single frame 0x00..0x1F with latency measurement
      track = 1; seen_start = 0; seen_beat = 0;
      push_one(8'h00);
      p0 = push_cyc;
      fork
         push_seq(31, 8'h01, 0, 0, 0);
         finish_frame(5);
      join
      track = 0;
      chk("lat_push_to_start", start_cyc - p0, 1);
      chk("lat_push_to_beat", beat_cyc - p0, 3);
      chk("first_beat_value", beat_val, 8'h00);

      // Underflow gaps: one byte every 3 cycles
      s0 = starts;
      fork
         push_seq(32, 8'h00, 1, 2, 2);
         finish_frame($urandom_range(8, 1));
      join
      chk("gap_frame_starts", starts - s0, 1);

      // Wrap and back-to-back frames
      s0 = starts;
      fork
         push_seq(64, 8'h40, 0, 0, 0);
         begin finish_frame(3); finish_frame(2); end
      join
      chk("b2b_frame_starts", starts - s0, 2);

      // Stray finish during streaming
      s0 = starts;
      fork
         push_seq(32, 8'h00, 1, 0, 3);
         begin
            wait_beats(10, ok);
            finish = 1'b1; idle(1); finish = 1'b0;
            finish_frame(4);
         end
      join
      chk("stray_finish_starts", starts - s0, 1);

      // Full FIFO while waiting for finish
      fork
         push_seq(32, 8'h00, 1, 0, 1);
         wait_frame_full(ok);
      join
      acc = 0;
      host_valid = 1'b1;
      host_data = 8'hC0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (host_ready) acc++;
         @(posedge clk); #1;
         host_data = 8'(8'hC0 + acc);
      end
      chk("full_accepted", acc, DEPTH);
      chk("full_ready_low", host_ready, 0);
      finish = 1'b1;
      @(posedge clk); #1; finish = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (valid_input) begin
            chk("ready_on_first_pop", host_ready, 1);
            break;
         end
         chk("ready_low_until_pop", host_ready, 0);
      end
      @(posedge clk); #1; host_valid = 1'b0;
      fork
         push_seq(N_ELEM - DEPTH - 1, 8'h00, 1, 0, 1);
         finish_frame(2);
      join

      // Reset mid-frame at element 17
      fork
         push_seq(32, 8'h00, 1, 0, 2);
         begin
            wait_beats(17, ok);
            abort = 1; host_valid = 1'b0;
            #2 rst = 1'b0;
            #1;
            chk("midrst_start_in", start_in, 0);
            chk("midrst_valid_input", valid_input, 0);
            chk("midrst_x_load", X_load, 8'h00);
            chk("midrst_busy", busy, 0);
            chk("midrst_host_ready", host_ready, 1);
            repeat (2) @(negedge clk);
            rst = 1'b1;
         end
      join
      abort = 0;
      @(posedge clk); #1;
      track = 1; seen_start = 0; seen_beat = 0;
      push_one(8'hA5);
      p0 = push_cyc;
      fork
         push_seq(N_ELEM - 1, 8'h00, 1, 0, 1);
         finish_frame(3);
      join
      track = 0;
      chk("postrst_lat_start", start_cyc - p0, 1);
      chk("postrst_lat_beat", beat_cyc - p0, 3);
      chk("postrst_first_beat", beat_val, 8'hA5);

      idle(5);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("total_starts", starts, 9);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/x_input_feeder.md
X_INPUT_FEEDER -- requirements
Module: x_input_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO depth in bytes (power of two, at least 2).
REQ-002 SHALL have parameter N_ELEM, default 32, meaning X bytes per matrix frame.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port host_data  input  8  byte from host.
REQ-006 SHALL have port host_valid  input  1  host_data valid this cycle.
REQ-007 SHALL have port host_ready  output  1  FIFO can accept; equals (fifo count != DEPTH), combinational from registered count.
REQ-008 SHALL have port finish  input  1  single-cycle done pulse from the matrix core.
REQ-009 SHALL have port start_in  output  1  registered one-cycle frame start pulse to the core.
REQ-010 SHALL have port X_load  output  8  registered X byte to the core.
REQ-011 SHALL have port valid_input  output  1  registered qualifier for X_load.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL accept (push) a byte when host_valid and host_ready are both high at a clock edge.
REQ-014 SHALL store bytes in a DEPTH-entry circular FIFO; read/write pointers wrap from DEPTH-1 to 0.
REQ-015 SHALL pop at most one byte per cycle, only in STREAM and only when count > 0 at the start of that cycle; a byte pushed into an empty FIFO cannot be popped in the same cycle.
REQ-016 SHALL update count by +1 (push only), -1 (pop only), 0 (both or neither); simultaneous push and pop SHALL be legal whenever 0 < count < DEPTH.
REQ-017 SHALL implement FSM states IDLE, START, STREAM, WAIT_DONE.
REQ-018 IDLE -> START when count > 0; otherwise remain in IDLE.
REQ-019 START: start_in = 1 for exactly this one cycle, no pop; always -> STREAM on the next cycle.
REQ-020 STREAM: each pop SHALL register the popped byte into X_load and set valid_input = 1 on the following cycle; cycles without a pop SHALL drive valid_input = 0 while X_load holds its last value.
REQ-021 SHALL hold a 6-bit element counter, cleared on entering STREAM and incremented per pop; on the pop that makes it N_ELEM the FSM -> WAIT_DONE.
REQ-022 WAIT_DONE: no pops; finish = 1 -> IDLE on the next cycle; pushes continue while host_ready is high.
REQ-023 SHALL ignore finish in IDLE, START and STREAM.
REQ-024 SHALL never assert start_in and valid_input in the same cycle.
REQ-025 SHALL give minimum latency from the push edge of a byte into an empty FIFO in IDLE to that byte on X_load with valid_input = 1 of 3 cycles (push, START, pop register).
REQ-026 SHALL emit bytes in exact push order with no loss or duplication, across frame boundaries and pointer wrap.

Reset
REQ-027 rst low SHALL asynchronously clear FSM to IDLE, pointers, count and element counter to 0, start_in = 0, valid_input = 0, X_load = 8'h00, busy = 0, giving host_ready = 1.
REQ-028 Reset mid-frame SHALL discard all FIFO contents and partial-frame progress; the first frame after reset release starts from element 0.
REQ-029 After reset release, the first possible start_in SHALL be one cycle after the first push.

Verification
REQ-030 Single frame: push 0x00..0x1F back-to-back, finish pulse 5 cycles after the 32nd valid_input -> one start_in pulse, 32 valid_input beats carrying 0x00..0x1F in order, busy falls the cycle after finish.
REQ-031 Full/backpressure: hold host_valid high with FSM in WAIT_DONE -> host_ready drops after 8 pushes, 9th byte not accepted, no overflow; after finish, host_ready rises on the first pop.
REQ-032 Underflow gaps: push one byte every 3 cycles -> valid_input has gaps, 32 beats total, X_load holds during gaps, no spurious beats.
REQ-033 Wrap and back-to-back frames: push 64 bytes 0x40..0x7F, finish after each frame -> two start_in pulses, second frame carries 0x60..0x7F, pointers wrapped 8 times without corruption.
REQ-034 Stray finish: pulse finish during STREAM at element 10 -> ignored, frame completes with 32 beats.
REQ-035 Reset mid-frame: assert rst at element 17 -> outputs 0 immediately, host_ready = 1; push 0xA5 after release -> start_in next cycle, 0xA5 is first X_load beat.
